// File: rtl/btn_pkg.sv
// Shared definitions for the button action decoder: action-kind codes,
// gesture FSM state encoding and a small elaboration-time helper.
package btn_pkg;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_SINGLE = 2'b01;
    localparam logic [1:0] KIND_DOUBLE = 2'b10;
    localparam logic [1:0] KIND_LONG   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        WAIT2   = 2'b10,
        PEND    = 2'b11
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level
// with a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic clear_n,
    input  logic btn_raw,
    output logic level,
    output logic press_edge
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          edge_q, edge_d;

    // The counter tracks how long the synchronised value has disagreed with
    // the debounced level; any agreement restarts the count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        edge_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            edge_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            edge_q  <= edge_d;
        end
    end

    assign level      = level_q;
    assign press_edge = edge_q;

endmodule

// File: rtl/btn_action_decoder.sv
// Turns NUM_BTNS raw buttons into one pending single/double(/long) action held
// until ack. Long-press detection is built only when LONG_PRESS_EN is defined.
module btn_action_decoder
    import btn_pkg::*;
#(
    parameter int                  NUM_BTNS    = 5,
    parameter int                  DEBOUNCE    = 16,
    parameter int                  DBL_WINDOW  = 1000,
    parameter logic [NUM_BTNS-1:0] DBL_MASK    = NUM_BTNS'(1),
    parameter int                  LONG_CYCLES = 5000,
    parameter int                  IDX_W       = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                dbl_en,
    input  logic                ack,
    output logic                act_valid,
    output logic [1:0]          act_kind,
    output logic [IDX_W-1:0]    act_idx
);

    localparam int CNT_W = $clog2(max_int(DBL_WINDOW, LONG_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DBL_C   = CNT_W'(DBL_WINDOW);
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
`endif

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press_edge;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_deb (
            .clk        (clk),
            .clear_n    (clear_n),
            .btn_raw    (btn_raw[g]),
            .level      (level[g]),
            .press_edge (press_edge[g])
        );
    end

    // Lowest index wins; the other simultaneous edges are simply not used.
    logic             any_edge;
    logic [IDX_W-1:0] win_idx;
    logic             elig;

    always_comb begin
        any_edge = |press_edge;
        win_idx  = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (press_edge[i]) win_idx = IDX_W'(i);
        end
        elig = dbl_en & DBL_MASK[win_idx];
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (any_edge) begin
                    idx_d = win_idx;
                    cnt_d = '0;
                    if (elig) begin
                        state_d = PRESSED;
                    end else begin
                        state_d = PEND;
                        kind_d  = KIND_SINGLE;
                    end
                end
            end
            PRESSED: begin
                cnt_d = cnt_inc;
                if (!level[idx_q]) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end
`ifdef LONG_PRESS_EN
                else if (cnt_q >= LONG_C) begin
                    state_d = PEND;
                    kind_d  = KIND_LONG;
                end
`endif
            end
            WAIT2: begin
                cnt_d = cnt_inc;
                // A second press of the same button after the window closes,
                // or any other button's press, ends the gesture as a single.
                if (press_edge[idx_q] && (cnt_q < DBL_C)) begin
                    state_d = PEND;
                    kind_d  = KIND_DOUBLE;
                end else if ((cnt_q >= DBL_C) || any_edge) begin
                    state_d = PEND;
                    kind_d  = KIND_SINGLE;
                end
            end
            PEND: begin
                if (ack) begin
                    state_d = IDLE;
                    kind_d  = KIND_NONE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            kind_q  <= KIND_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    // The gesture index is tracked before PEND; only show it with a valid action.
    assign act_valid = (state_q == PEND);
    assign act_kind  = act_valid ? kind_q : KIND_NONE;
    assign act_idx   = act_valid ? idx_q : '0;

endmodule

// File: tb/tb_btn_action_decoder.sv
// Directed bench for btn_action_decoder with DEBOUNCE=4, DBL_WINDOW=20,
// LONG_CYCLES=50; expected actions are queued as {kind, idx}.
module tb_btn_action_decoder;

    localparam logic [1:0] K_NONE   = 2'b00;
    localparam logic [1:0] K_SINGLE = 2'b01;
    localparam logic [1:0] K_DOUBLE = 2'b10;
    localparam logic [1:0] K_LONG   = 2'b11;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [4:0] btn_raw;
    logic       dbl_en;
    logic       ack;
    logic       act_valid;
    logic [1:0] act_kind;
    logic [2:0] act_idx;

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    btn_action_decoder #(
        .NUM_BTNS    (5),
        .DEBOUNCE    (4),
        .DBL_WINDOW  (20),
        .DBL_MASK    (5'b00001),
        .LONG_CYCLES (50)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .btn_raw   (btn_raw),
        .dbl_en    (dbl_en),
        .ack       (ack),
        .act_valid (act_valid),
        .act_kind  (act_kind),
        .act_idx   (act_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet(input string tag, input int n);
        int hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (act_valid) hits++;
        end
        check(tag, hits, 0);
    endtask

    task automatic expect_act(input logic [1:0] kind, input logic [2:0] idx);
        exp_q.push_back({kind, idx});
    endtask

    task automatic collect(input string tag, input int budget);
        logic [4:0] e;
        int waited = 0;
        e = exp_q.pop_front();
        while (!act_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_seen"}, act_valid, 1);
        if (act_valid) begin
            check({tag, "_kind"}, act_kind, e[4:3]);
            check({tag, "_idx"}, act_idx, e[2:0]);
        end
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, "_ack_valid"}, act_valid, 0);
        check({tag, "_ack_kind"}, act_kind, K_NONE);
        check({tag, "_ack_idx"}, act_idx, 0);
    endtask

    initial begin
        clear_n = 1'b0;
        btn_raw = '0;
        dbl_en  = 1'b1;
        ack     = 1'b0;
        cyc(2);
        check("rst_valid", act_valid, 0);
        check("rst_kind", act_kind, K_NONE);
        check("rst_idx", act_idx, 0);
        clear_n = 1'b1;
        cyc(2);

        // Glitches on button 2, then a real 10-cycle press.
        repeat (2) begin
            btn_raw[2] = 1'b1; cyc(2);
            btn_raw[2] = 1'b0; cyc(3);
        end
        quiet("t1_glitch", 10);
        btn_raw[2] = 1'b1;
        expect_act(K_SINGLE, 3'd2);
        collect("t1", 15);
        cyc(3);
        check("t1_hold_valid", act_valid, 1);
        btn_raw[2] = 1'b0;
        cyc(3);
        check("t1_noack_valid", act_valid, 1);
        check("t1_noack_idx", act_idx, 2);
        do_ack("t1");
        quiet("t1_once", 20);

        // Double click on button 0 with the second press well inside the window.
        btn_raw[0] = 1'b1; cyc(10);
        btn_raw[0] = 1'b0; cyc(16);
        btn_raw[0] = 1'b1;
        expect_act(K_DOUBLE, 3'd0);
        collect("t2_dbl", 15);
        cyc(3);
        btn_raw[0] = 1'b0;
        do_ack("t2_dbl");
        quiet("t2_after_dbl", 10);

        // Second press too late: single at window expiry, then another single.
        btn_raw[0] = 1'b1; cyc(10);
        btn_raw[0] = 1'b0;
        expect_act(K_SINGLE, 3'd0);
        collect("t2_exp1", 40);
        do_ack("t2_exp1");
        cyc(2);
        btn_raw[0] = 1'b1; cyc(10);
        btn_raw[0] = 1'b0;
        expect_act(K_SINGLE, 3'd0);
        collect("t2_exp2", 40);
        do_ack("t2_exp2");
        quiet("t2_after_exp", 10);

        // Another button pressed inside the window closes the gesture as a single.
        btn_raw[0] = 1'b1; cyc(10);
        btn_raw[0] = 1'b0; cyc(10);
        btn_raw[3] = 1'b1;
        expect_act(K_SINGLE, 3'd0);
        collect("t3_other", 20);
        do_ack("t3_other");
        cyc(5);
        btn_raw[3] = 1'b0;
        quiet("t3_b3_none", 20);
        btn_raw[3] = 1'b1;
        expect_act(K_SINGLE, 3'd3);
        collect("t3_b3_repress", 15);
        do_ack("t3_b3_repress");
        cyc(3);
        btn_raw[3] = 1'b0;
        cyc(10);

        // Double-click disabled: immediate single on press; priority on ties.
        dbl_en = 1'b0;
        btn_raw[0] = 1'b1;
        expect_act(K_SINGLE, 3'd0);
        collect("t4_nodbl", 12);
        check("t4_still_held", btn_raw[0], 1);
        do_ack("t4_nodbl");
        btn_raw[0] = 1'b0;
        quiet("t4_release", 15);
        btn_raw[1] = 1'b1;
        btn_raw[4] = 1'b1;
        expect_act(K_SINGLE, 3'd1);
        collect("t4_prio", 12);
        do_ack("t4_prio");
        cyc(3);
        btn_raw[1] = 1'b0;
        btn_raw[4] = 1'b0;
        quiet("t4_b4_none", 20);

        // Press while an action is pending is lost.
        btn_raw[2] = 1'b1;
        expect_act(K_SINGLE, 3'd2);
        collect("t5_pend", 12);
        btn_raw[1] = 1'b1;
        cyc(12);
        check("t5_keep_valid", act_valid, 1);
        check("t5_keep_kind", act_kind, K_SINGLE);
        check("t5_keep_idx", act_idx, 2);
        do_ack("t5_pend");
        quiet("t5_no_refire", 15);
        btn_raw[1] = 1'b0;
        btn_raw[2] = 1'b0;
        quiet("t5_release", 15);

        // Reset in the middle of WAIT2.
        dbl_en = 1'b1;
        btn_raw[0] = 1'b1; cyc(10);
        btn_raw[0] = 1'b0; cyc(12);
        clear_n = 1'b0;
        #1;
        check("rst_mid_valid", act_valid, 0);
        check("rst_mid_kind", act_kind, K_NONE);
        check("rst_mid_idx", act_idx, 0);
        cyc(2);
        clear_n = 1'b1;
        quiet("rst_mid_none", 40);

        // 60-cycle hold of button 0.
        btn_raw[0] = 1'b1;
`ifdef LONG_PRESS_EN
        expect_act(K_LONG, 3'd0);
        collect("t6_long", 70);
        do_ack("t6_long");
        cyc(2);
        btn_raw[0] = 1'b0;
        quiet("t6_long_release", 40);
`else
        quiet("t6_hold_none", 60);
        btn_raw[0] = 1'b0;
        expect_act(K_SINGLE, 3'd0);
        collect("t6_hold_single", 40);
        do_ack("t6_hold_single");
        quiet("t6_after", 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
